seq_booth_divider: RTL
======================

# seq_booth_divider

Iterative radix-2 restoring integer divider for the `simd_vec_mac` datapath. It is the inverse operation of the pipelined Booth multiplier. It produces quotient and remainder for signed or unsigned operands using one shift/subtract step per clock. Ready/valid handshakes are used on both sides, so a normalization or scaling stage can drive it after MAC accumulation.

## Interface
- `DIV_W`, default 16: operand, quotient and remainder width; must be ≥ 2.
- `CNT_W`, default `$clog2(DIV_W+1)`: width of the iteration counter; derived, do not override.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  operands valid.
- `ready_o`  out  1  divider can accept an operation.
- `signed_i`  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- `dividend_i`  in  `DIV_W`  dividend.
- `divisor_i`  in  `DIV_W`  divisor.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  downstream accepts the result.
- `quotient_o`  out  `DIV_W`  quotient.
- `remainder_o`  out  `DIV_W`  remainder.
- `div_by_zero_o`  out  1  divisor was zero; qualified by `valid_o`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- `ready_o` = (state == IDLE). `valid_o` = (state == DONE).
- **IDLE**
  - On `valid_i && ready_o`: capture the operation and go to CALC with counter = 0.
  - Captured values: `signed_i`; the dividend sign `sd = signed_i & dividend_i[MSB]`; the divisor sign `sv = signed_i & divisor_i[MSB]`.
  - Magnitudes are stored as `DIV_W`-bit unsigned values (absolute value if signed). |MIN| = 2^(DIV_W-1) fits as unsigned.
  - The zero-divisor flag is captured.
- **CALC**, one step per cycle, `DIV_W` cycles:
  - Partial remainder register is `DIV_W+1` bits; it shifts left and takes in the next dividend MSB.
  - Trial = partial − |divisor|.
  - If trial ≥ 0: partial ← trial and shift 1 into the quotient. Otherwise keep partial and shift 0.
  - The counter increments each step. After step `DIV_W` (counter = `DIV_W-1` at the edge), go to FIX.
- **FIX**, one cycle: compute the outputs, register them, go to DONE.
  - Quotient = −Q if `sd^sv`, else Q. Remainder = −R if `sd`, else R.
  - Signed results truncate toward zero; the remainder carries the dividend's sign.
  - Divide by zero overrides: `quotient_o` = all ones, `remainder_o` = original dividend_i, `div_by_zero_o` = 1. Latency is unchanged.
  - Signed MIN / −1: `quotient_o` = MIN (wraps), `remainder_o` = 0, no flag.
- **DONE**: outputs are held stable while `ready_i` = 0. On `valid_o && ready_i`, go to IDLE.
- `valid_i` is ignored outside IDLE. Inputs need not be held after acceptance.
- Widths: all arithmetic is done in `DIV_W+1` bits; there is no other width growth.

## Timing
- Reset values: state IDLE, `ready_o` = 1, `valid_o` = 0, `quotient_o` = 0, `remainder_o` = 0, `div_by_zero_o` = 0, counter = 0.
- Latency: if operands are accepted at the end of cycle 0, `valid_o` = 1 in cycle `DIV_W+2`. This is fixed and independent of the data.
- Handshake from DONE: when `ready_i` = 1 in DONE, `ready_o` = 1 the next cycle.
- Maximum throughput: one result per `DIV_W+3` cycles.
- Asserting `rst_n` mid-operation aborts the operation. All registers return to their reset values and the operation is never reported.
- No combinational path from any input to any output. `ready_o` and `valid_o` are decoded from registered state.

## Test plan
- **Signed positive.** Signed, 100 / 7, `ready_i` = 1. Require `quotient_o` = 14 and `remainder_o` = 2. Require `valid_o` exactly in cycle 18 for acceptance in cycle 0, high for one cycle, then `ready_o` = 1.
- **Sign cases.** Signed: −100 / 7 gives −14 r −2; 100 / −7 gives −14 r 2; −100 / −7 gives 14 r −2.
- **Edge cases.**
  - Signed −32768 / −1 gives q = 0x8000, r = 0, `div_by_zero_o` = 0.
  - Signed 5 / 0 gives q = 0xFFFF, r = 5, `div_by_zero_o` = 1, with the same latency.
- **Unsigned.** 0xFFFF / 0x0002 gives q = 0x7FFF, r = 1. Signed 0xFFFF / 0x0002 (−1 / 2) gives q = 0, r = 0xFFFF.
- **Backpressure.**
  - Hold `ready_i` = 0 for 5 cycles in DONE: outputs stay stable and `valid_o` stays 1.
  - Pulse `valid_i` with 9 / 3 during CALC: the operands are ignored and the original result is unchanged.
  - Back-to-back operations complete every 19 cycles.
- **Reset mid-operation.** Drop `rst_n` during cycle 8 of CALC. Outputs return to reset values, no `valid_o` occurs, and the next operation 50 / 5 gives q = 10, r = 0.

Source files
------------

// File: rtl/seq_booth_divider.sv
// Iterative radix-2 restoring divider: signed/unsigned quotient and remainder,
// one shift/subtract step per clock, ready/valid on both sides.
module seq_booth_divider #(
    parameter int DIV_W = 16,
    parameter int CNT_W = $clog2(DIV_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             signed_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DIV_W-1:0] quotient_o,
    output logic [DIV_W-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [CNT_W-1:0] cnt_r;
    logic             sd_r, sv_r, zero_r;
    logic [DIV_W-1:0] orig_r;
    logic [DIV_W-1:0] dsr_r;
    logic [DIV_W-1:0] quo_r;   // dividend bits shift out of the top, quotient bits in at the bottom
    logic [DIV_W-1:0] part_r;  // restored remainder always fits DIV_W bits
    logic [DIV_W:0]   shift_s, trial_s;
    logic             last_s;
    logic [DIV_W-1:0] quotient_r, remainder_r;
    logic             dbz_r;

    function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
        neg_if = en ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign ready_o       = (state_r == IDLE);
    assign valid_o       = (state_r == DONE);
    assign quotient_o    = quotient_r;
    assign remainder_o   = remainder_r;
    assign div_by_zero_o = dbz_r;

    assign shift_s = {part_r, quo_r[DIV_W-1]};
    assign trial_s = shift_s - {1'b0, dsr_r};
    assign last_s  = (cnt_r == CNT_W'(DIV_W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_i) state_s = CALC;
                else         state_s = IDLE;
            end
            CALC: begin
                if (last_s) state_s = FIX;
                else        state_s = CALC;
            end
            FIX:  state_s = DONE;
            DONE: begin
                if (ready_i) state_s = IDLE;
                else         state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, shift/subtract iteration and result correction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            sd_r        <= 1'b0;
            sv_r        <= 1'b0;
            zero_r      <= 1'b0;
            orig_r      <= {DIV_W{1'b0}};
            dsr_r       <= {DIV_W{1'b0}};
            quo_r       <= {DIV_W{1'b0}};
            part_r      <= {DIV_W{1'b0}};
            quotient_r  <= {DIV_W{1'b0}};
            remainder_r <= {DIV_W{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        sd_r   <= signed_i & dividend_i[DIV_W-1];
                        sv_r   <= signed_i & divisor_i[DIV_W-1];
                        zero_r <= (divisor_i == {DIV_W{1'b0}});
                        orig_r <= dividend_i;
                        quo_r  <= neg_if(dividend_i, signed_i & dividend_i[DIV_W-1]);
                        dsr_r  <= neg_if(divisor_i, signed_i & divisor_i[DIV_W-1]);
                        part_r <= {DIV_W{1'b0}};
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!trial_s[DIV_W]) begin
                        part_r <= trial_s[DIV_W-1:0];
                        quo_r  <= {quo_r[DIV_W-2:0], 1'b1};
                    end else begin
                        part_r <= shift_s[DIV_W-1:0];
                        quo_r  <= {quo_r[DIV_W-2:0], 1'b0};
                    end
                end
                FIX: begin
                    // MIN / -1 needs no special case: |MIN| / 1 negated twice wraps back to MIN
                    if (zero_r) begin
                        quotient_r  <= {DIV_W{1'b1}};
                        remainder_r <= orig_r;
                        dbz_r       <= 1'b1;
                    end else begin
                        quotient_r  <= neg_if(quo_r, sd_r ^ sv_r);
                        remainder_r <= neg_if(part_r, sd_r);
                        dbz_r       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
